traffic_light_fsm: RTL

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

---
 rtl/traffic_light_fsm.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// traffic_light_fsm
//
// Highway / farm-road intersection controller. The highway rests on green and
// yields to the farm road only after a minimum green time and when the farm
// car sensor reports a vehicle. Every phase is timed in seconds from an 8-bit
// timer that counts sec_en pulses. The timer saturates at 255 and clears on
// every state change.
//
// Optional feature: define PED_REQ_EN to add a pedestrian button and a WALK
// phase. A button press is latched as "pending". Pending then forces a
// highway yield once the minimum green time has expired. Cars are serviced
// first. A yield caused by pending alone goes to WALK instead of the farm
// phase.
//
// Ports
//   clk        in   1  clock
//   rst_n      in   1  asynchronous active-low reset (enters HG, timer 0)
//   sec_en     in   1  one-clk pulse per second
//   car        in   1  farm-road vehicle present (level)
//   ped_req    in   1  pedestrian button pulse          (PED_REQ_EN only)
//   walk       out  1  walk lamp, high only in WALK     (PED_REQ_EN only)
//   hwy_light  out  3  highway lamps, one-hot {R,Y,G}
//   farm_light out  3  farm-road lamps, one-hot {R,Y,G}
//   state_o    out  3  current state code (debug)
// ---------------------------------------------------------------------------
module traffic_light_fsm #(
    parameter int HWY_GREEN_MIN  = 10,
    parameter int YELLOW_TIME    = 3,
    parameter int ALLRED_TIME    = 1,
    parameter int FARM_GREEN_MAX = 8,
    parameter int WALK_TIME      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_en,
    input  logic       car,
`ifdef PED_REQ_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] hwy_light,
    output logic [2:0] farm_light,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_HG   = 3'd0,
        S_HY   = 3'd1,
        S_AR1  = 3'd2,
        S_FG   = 3'd3,
        S_FY   = 3'd4,
        S_AR2  = 3'd5
`ifdef PED_REQ_EN
        ,S_WALK = 3'd6
`endif
    } state_t;

    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_G = 3'b001;

    localparam logic [7:0] T_HG_MIN = 8'(HWY_GREEN_MIN);
    localparam logic [7:0] T_YEL    = 8'(YELLOW_TIME);
    localparam logic [7:0] T_ALLRED = 8'(ALLRED_TIME);
    localparam logic [7:0] T_FG_MAX = 8'(FARM_GREEN_MAX);

    // Every phase time is compared against the 8-bit timer.
    if (HWY_GREEN_MIN > 255 || YELLOW_TIME > 255 || ALLRED_TIME > 255 ||
        FARM_GREEN_MAX > 255 || WALK_TIME > 255) begin : g_param_check
        $error("traffic_light_fsm: phase times must fit the 8-bit timer");
    end

    state_t     state;
    logic [7:0] timer;

`ifdef PED_REQ_EN
    localparam logic [7:0] T_WALK = 8'(WALK_TIME);
    logic pending;
    logic ped_only;   // current HY was entered for the pedestrian alone
`endif

    // The timer is incremented by default. Each transition below overrides
    // the increment with a clear, so a coincident sec_en never leaks into
    // the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HG;
            timer <= '0;
`ifdef PED_REQ_EN
            pending  <= 1'b0;
            ped_only <= 1'b0;
`endif
        end else begin
            if (sec_en && timer != 8'hFF)
                timer <= timer + 8'd1;

            case (state)
                S_HG: begin
`ifdef PED_REQ_EN
                    if (timer >= T_HG_MIN && (car || pending)) begin
                        state    <= S_HY;
                        timer    <= '0;
                        ped_only <= !car;   // the car wins; pending stays set
                    end
`else
                    if (timer >= T_HG_MIN && car) begin
                        state <= S_HY;
                        timer <= '0;
                    end
`endif
                end
                S_HY: begin
                    if (timer == T_YEL) begin
                        timer <= '0;
`ifdef PED_REQ_EN
                        if (ped_only) begin
                            state   <= S_WALK;
                            pending <= 1'b0;
                        end else begin
                            state <= S_AR1;
                        end
`else
                        state <= S_AR1;
`endif
                    end
                end
                S_AR1: begin
                    if (timer == T_ALLRED) begin
                        state <= S_FG;
                        timer <= '0;
                    end
                end
                S_FG: begin
                    if (!car || timer == T_FG_MAX) begin
                        state <= S_FY;
                        timer <= '0;
                    end
                end
                S_FY: begin
                    if (timer == T_YEL) begin
                        state <= S_AR2;
                        timer <= '0;
                    end
                end
                S_AR2: begin
                    if (timer == T_ALLRED) begin
                        state <= S_HG;
                        timer <= '0;
                    end
                end
`ifdef PED_REQ_EN
                S_WALK: begin
                    if (timer == T_WALK) begin
                        state <= S_HG;
                        timer <= '0;
                    end
                end
`endif
                // An unknown code is recovered through the all-red
                // clearance, so the highway is never released straight
                // from a corrupted state.
                default: begin
                    state <= S_AR2;
                    timer <= '0;
                end
            endcase

`ifdef PED_REQ_EN
            // A press on the same cycle as WALK entry is kept for the next
            // cycle.
            if (ped_req)
                pending <= 1'b1;
`endif
        end
    end

    // The lamps are decoded straight from the state register. Any code
    // without a green or yellow phase, including an illegal code, shows red
    // on both roads.
    always_comb begin
        hwy_light  = L_R;
        farm_light = L_R;
        case (state)
            S_HG:    hwy_light  = L_G;
            S_HY:    hwy_light  = L_Y;
            S_FG:    farm_light = L_G;
            S_FY:    farm_light = L_Y;
            default: ;
        endcase
    end

`ifdef PED_REQ_EN
    assign walk = (state == S_WALK);
`endif

    assign state_o = state;

endmodule
